// File: rtl/pic8259_pkg.sv
// Shared types and bit positions for the 8259A command-word front end.
package pic8259_pkg;

    typedef enum logic [2:0] {
        UNINIT,
        WAIT_ICW2,
        WAIT_ICW3,
        WAIT_ICW4,
        READY
    } seq_state_t;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_ICW1,
        CMD_ICW2,
        CMD_ICW3,
        CMD_ICW4,
        CMD_OCW1,
        CMD_OCW2,
        CMD_OCW3
    } cmd_t;

    localparam int ICW1_SEL_BIT  = 4;
    localparam int OCW3_SEL_BIT  = 3;
    localparam int ICW1_SNGL_BIT = 1;
    localparam int ICW1_IC4_BIT  = 0;

endpackage

// File: rtl/command_word_sequencer_write_edge_detector.sv
// Write-cycle edge detector: one pulse per write_request pulse, with the A0/data
// to decode. Falling-edge mode decodes the last values captured during the write.
module write_edge_detector #(
    parameter bit LATCH_ON_WRITE_END = 1'b1
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_write_request,
    input  logic       i_address_0,
    input  logic [7:0] i_data,
    output logic       o_edge,
    output logic       o_address_0,
    output logic [7:0] o_data
);

    logic r_wr_prev;
    logic r_armed;

    // r_armed stays low until write_request has been seen low, so a write that
    // straddles reset cannot produce a command.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wr_prev <= 1'b0;
            r_armed   <= ~i_write_request;
        end else begin
            r_wr_prev <= i_write_request;
            if (!i_write_request) begin
                r_armed <= 1'b1;
            end
        end
    end

    generate
        if (LATCH_ON_WRITE_END) begin : g_fall
            logic       r_address_0;
            logic [7:0] r_data;

            always_ff @(posedge i_clock) begin
                if (i_reset) begin
                    r_address_0 <= 1'b0;
                    r_data      <= 8'h00;
                end else if (i_write_request) begin
                    r_address_0 <= i_address_0;
                    r_data      <= i_data;
                end
            end

            assign o_edge      = r_armed & r_wr_prev & ~i_write_request;
            assign o_address_0 = r_address_0;
            assign o_data      = r_data;
        end else begin : g_rise
            assign o_edge      = r_armed & ~r_wr_prev & i_write_request;
            assign o_address_0 = i_address_0;
            assign o_data      = i_data;
        end
    endgenerate

endmodule

// File: rtl/command_word_sequencer.sv
// 8259A command-word sequencer: decodes CPU writes into ICW/OCW strobes and tracks init.
// Optional macro CMD_SEQ_PROTOCOL_ERROR_EN adds a sticky protocol_error output.
module command_word_sequencer
    import pic8259_pkg::*;
#(
    parameter bit LATCH_ON_WRITE_END = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       write_request,
    input  logic       address_0,
    input  logic [7:0] internal_data_bus,
    output logic       write_initial_command_word_1,
    output logic       write_initial_command_word_2,
    output logic       write_initial_command_word_3,
    output logic       write_initial_command_word_4,
    output logic       write_operation_control_word_1,
    output logic       write_operation_control_word_2,
    output logic       write_operation_control_word_3,
    output logic       load_default_icw4,
    output logic       initialization_busy,
    output logic       initialized,
    output logic [7:0] command_data
`ifdef CMD_SEQ_PROTOCOL_ERROR_EN
    ,
    output logic       protocol_error
`endif
);

    logic       w_edge;
    logic       w_address_0;
    logic [7:0] w_data;

    write_edge_detector #(
        .LATCH_ON_WRITE_END(LATCH_ON_WRITE_END)
    ) u_write_edge_detector (
        .i_clock         (clock),
        .i_reset         (reset),
        .i_write_request (write_request),
        .i_address_0     (address_0),
        .i_data          (internal_data_bus),
        .o_edge          (w_edge),
        .o_address_0     (w_address_0),
        .o_data          (w_data)
    );

    seq_state_t r_state;
    seq_state_t w_next_state;
    cmd_t       r_cmd;
    cmd_t       w_cmd;
    logic       r_sngl;
    logic       r_ic4;
    logic       r_load_default;
    logic       w_load_default;
    logic [7:0] r_command_data;

    // ICW1 wins in every state, so a restart is possible mid-sequence.
    always_comb begin
        w_cmd = CMD_NONE;
        if (w_edge) begin
            if (!w_address_0 && w_data[ICW1_SEL_BIT]) begin
                w_cmd = CMD_ICW1;
            end else begin
                case (r_state)
                    WAIT_ICW2: if (w_address_0) w_cmd = CMD_ICW2;
                    WAIT_ICW3: if (w_address_0) w_cmd = CMD_ICW3;
                    WAIT_ICW4: if (w_address_0) w_cmd = CMD_ICW4;
                    READY: begin
                        if (w_address_0)                 w_cmd = CMD_OCW1;
                        else if (w_data[OCW3_SEL_BIT])   w_cmd = CMD_OCW3;
                        else                             w_cmd = CMD_OCW2;
                    end
                    default: w_cmd = CMD_NONE;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= UNINIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // State advances from the registered strobe, one cycle after the decode.
    always_comb begin
        w_next_state   = r_state;
        w_load_default = 1'b0;
        case (r_cmd)
            CMD_ICW1: w_next_state = WAIT_ICW2;
            CMD_ICW2: begin
                if (!r_sngl) begin
                    w_next_state = WAIT_ICW3;
                end else if (r_ic4) begin
                    w_next_state = WAIT_ICW4;
                end else begin
                    w_next_state   = READY;
                    w_load_default = 1'b1;
                end
            end
            CMD_ICW3: begin
                if (r_ic4) begin
                    w_next_state = WAIT_ICW4;
                end else begin
                    w_next_state   = READY;
                    w_load_default = 1'b1;
                end
            end
            CMD_ICW4: w_next_state = READY;
            default:  w_next_state = r_state;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cmd          <= CMD_NONE;
            r_command_data <= 8'h00;
            r_sngl         <= 1'b0;
            r_ic4          <= 1'b0;
            r_load_default <= 1'b0;
        end else begin
            r_cmd          <= w_cmd;
            r_load_default <= w_load_default;
            if (w_cmd != CMD_NONE) begin
                r_command_data <= w_data;
            end
            if (r_cmd == CMD_ICW1) begin
                r_sngl <= r_command_data[ICW1_SNGL_BIT];
                r_ic4  <= r_command_data[ICW1_IC4_BIT];
            end
        end
    end

    assign write_initial_command_word_1   = (r_cmd == CMD_ICW1);
    assign write_initial_command_word_2   = (r_cmd == CMD_ICW2);
    assign write_initial_command_word_3   = (r_cmd == CMD_ICW3);
    assign write_initial_command_word_4   = (r_cmd == CMD_ICW4);
    assign write_operation_control_word_1 = (r_cmd == CMD_OCW1);
    assign write_operation_control_word_2 = (r_cmd == CMD_OCW2);
    assign write_operation_control_word_3 = (r_cmd == CMD_OCW3);
    assign load_default_icw4              = r_load_default;
    assign command_data                   = r_command_data;
    assign initialization_busy = (r_state == WAIT_ICW2) || (r_state == WAIT_ICW3) ||
                                 (r_state == WAIT_ICW4);
    assign initialized         = (r_state == READY);

`ifdef CMD_SEQ_PROTOCOL_ERROR_EN
    logic w_ignored;
    logic r_protocol_error;

    assign w_ignored = w_edge && (w_cmd == CMD_NONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_protocol_error <= 1'b0;
        end else if (w_ignored) begin
            r_protocol_error <= 1'b1;
        end else if (r_cmd == CMD_ICW1) begin
            r_protocol_error <= 1'b0;
        end
    end

    assign protocol_error = r_protocol_error;
`endif

endmodule
